// File: rtl/seg7_pkg.sv
// ============================================================================
// seg7_pkg : shared segment constants and glyph lookup for the scan driver
// Rev 1.0
// ============================================================================
`default_nettype none

package seg7_pkg;

   // Segment order is {a,b,c,d,e,f,g}, logical (active-high) sense.
   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam logic [6:0] GLYPH_0   = 7'b1111110;
   localparam logic [6:0] GLYPH_1   = 7'b0110000;
   localparam logic [6:0] GLYPH_2   = 7'b1101101;
   localparam logic [6:0] GLYPH_3   = 7'b1111001;
   localparam logic [6:0] GLYPH_4   = 7'b0110011;
   localparam logic [6:0] GLYPH_5   = 7'b1011011;
   localparam logic [6:0] GLYPH_6   = 7'b1011111;
   localparam logic [6:0] GLYPH_7   = 7'b1110010;
   localparam logic [6:0] GLYPH_8   = 7'b1111111;
   localparam logic [6:0] GLYPH_9   = 7'b1111011;
   localparam logic [6:0] GLYPH_A   = 7'b1110111;
   localparam logic [6:0] GLYPH_B   = 7'b0011111;
   localparam logic [6:0] GLYPH_C   = 7'b1001110;
   localparam logic [6:0] GLYPH_D   = 7'b0111101;
   localparam logic [6:0] GLYPH_E   = 7'b1001111;
   localparam logic [6:0] GLYPH_F   = 7'b1000111;

   function automatic logic [6:0] seg7_glyph(input logic [3:0] code, input logic hex_en);
      logic [6:0] g;
      case (code)
         4'h0:    g = GLYPH_0;
         4'h1:    g = GLYPH_1;
         4'h2:    g = GLYPH_2;
         4'h3:    g = GLYPH_3;
         4'h4:    g = GLYPH_4;
         4'h5:    g = GLYPH_5;
         4'h6:    g = GLYPH_6;
         4'h7:    g = GLYPH_7;
         4'h8:    g = GLYPH_8;
         4'h9:    g = GLYPH_9;
         4'hA:    g = hex_en ? GLYPH_A : SEG_BLANK;
         4'hB:    g = hex_en ? GLYPH_B : SEG_BLANK;
         4'hC:    g = hex_en ? GLYPH_C : SEG_BLANK;
         4'hD:    g = hex_en ? GLYPH_D : SEG_BLANK;
         4'hE:    g = hex_en ? GLYPH_E : SEG_BLANK;
         default: g = hex_en ? GLYPH_F : SEG_BLANK;
      endcase
      return g;
   endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_lzb_mask.sv
// ============================================================================
// seg7_lzb_mask : leading-zero blank mask for the displayed word
// Rev 1.0
// ============================================================================
`default_nettype none

module seg7_lzb_mask #(
   parameter int N_DIGITS = 4,
   parameter int LZB_EN   = 1
) (
   input  logic [4*N_DIGITS-1:0] num_i,
   input  logic [N_DIGITS-1:0]   dp_i,
   output logic [N_DIGITS-1:0]   blank_o
);

   logic w_run;

   // Walk down from the top digit; the run ends at the first nonzero code or set DP.
   always_comb begin
      blank_o = '0;
      w_run   = (LZB_EN != 0);
      for (int i = N_DIGITS - 1; i >= 1; i--) begin
         w_run      = w_run && (num_i[4*i +: 4] == 4'd0) && !dp_i[i];
         blank_o[i] = w_run;
      end
   end

endmodule

`default_nettype wire

// File: rtl/seg7_scan_driver.sv
// ============================================================================
// seg7_scan_driver : time-multiplexed N-digit 7-segment driver with guard slots
// Rev 1.0
// ============================================================================
`default_nettype none

module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int N_DIGITS    = 4,
   parameter int DIV         = 50000,
   parameter int GUARD       = 2,
   parameter int HEX_EN      = 0,
   parameter int LZB_EN      = 1,
   parameter int DIG_ACT_LOW = 1,
   parameter int SEG_ACT_LOW = 0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  load_i,
   input  logic [4*N_DIGITS-1:0] num_i,
   input  logic [N_DIGITS-1:0]   dp_i,
   output logic [6:0]            seg_o,
   output logic                  dp_out_o,
   output logic [N_DIGITS-1:0]   an_o,
   output logic                  frame_o
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int DW    = 5 * N_DIGITS;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_DIGITS - 1);

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [DW-1:0]       pend_q, pend_d;
   logic [DW-1:0]       disp_q, disp_d;
   logic [6:0]          seg_q, seg_d;
   logic                dpo_q, dpo_d;
   logic [N_DIGITS-1:0] an_q, an_d;
   logic                frame_q, frame_d;

   logic                w_boundary;
   logic                w_guard;
   logic [3:0]          w_code;
   logic                w_dp;
   logic                w_blank;
   logic [N_DIGITS-1:0] w_blank_mask;

   generate
      if (GUARD > 0) begin : g_guard
         assign w_guard = (cnt_q < CNT_W'(GUARD));
      end else begin : g_noguard
         assign w_guard = 1'b0;
      end
   endgenerate

   seg7_lzb_mask #(
      .N_DIGITS (N_DIGITS),
      .LZB_EN   (LZB_EN)
   ) u_lzb (
      .num_i   (disp_q[4*N_DIGITS-1:0]),
      .dp_i    (disp_q[DW-1:4*N_DIGITS]),
      .blank_o (w_blank_mask)
   );

   assign w_boundary = (cnt_q == CNT_MAX) && (idx_q == IDX_MAX);

   always_comb begin
      cnt_d   = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
      idx_d   = idx_q;
      if (cnt_q == CNT_MAX) begin
         idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
      end
      pend_d  = load_i ? {dp_i, num_i} : pend_q;
      // A LOAD landing on the boundary cycle goes straight into the new frame.
      disp_d  = w_boundary ? pend_d : disp_q;
      frame_d = w_boundary;

      w_code  = 4'd0;
      w_dp    = 1'b0;
      w_blank = 1'b0;
      an_d    = '0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            w_code  = disp_q[4*i +: 4];
            w_dp    = disp_q[4*N_DIGITS + i];
            w_blank = w_blank_mask[i];
            an_d[i] = 1'b1;
         end
      end

      seg_d = w_blank ? SEG_BLANK : seg7_glyph(w_code, HEX_EN != 0);
      dpo_d = w_dp;
      if (w_guard) begin
         an_d  = '0;
         seg_d = SEG_BLANK;
         dpo_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         idx_q   <= '0;
         pend_q  <= '0;
         disp_q  <= '0;
         seg_q   <= SEG_BLANK;
         dpo_q   <= 1'b0;
         an_q    <= '0;
         frame_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         pend_q  <= pend_d;
         disp_q  <= disp_d;
         seg_q   <= seg_d;
         dpo_q   <= dpo_d;
         an_q    <= an_d;
         frame_q <= frame_d;
      end
   end

   assign an_o     = (DIG_ACT_LOW != 0) ? ~an_q : an_q;
   assign seg_o    = (SEG_ACT_LOW != 0) ? ~seg_q : seg_q;
   assign dp_out_o = (SEG_ACT_LOW != 0) ? ~dpo_q : dpo_q;
   assign frame_o  = frame_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
// ============================================================================
// tb_seg7_scan_driver : directed checks on three driver configurations
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_seg7_scan_driver;

   localparam logic [6:0] BL = 7'b0000000;
   localparam logic [6:0] G0 = 7'b1111110;
   localparam logic [6:0] G1 = 7'b0110000;
   localparam logic [6:0] G2 = 7'b1101101;
   localparam logic [6:0] G3 = 7'b1111001;
   localparam logic [6:0] G4 = 7'b0110011;
   localparam logic [6:0] G5 = 7'b1011011;
   localparam logic [6:0] G9 = 7'b1111011;
   localparam logic [6:0] GA = 7'b1110111;
   localparam logic [6:0] GB = 7'b0011111;
   localparam logic [6:0] GC = 7'b1001110;
   localparam logic [6:0] GF = 7'b1000111;

   logic        clk = 1'b0;
   logic        rst;
   logic        load;
   logic [15:0] num;
   logic [3:0]  dp;

   logic [6:0] seg0, seg1, seg2;
   logic       dpo0, dpo1, dpo2;
   logic [3:0] an0, an1, an2;
   logic       frm0, frm1, frm2;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   // dut0: default polarity, no hex; dut1: hex glyphs; dut2: inverted polarities.
   seg7_scan_driver #(.N_DIGITS(4), .DIV(4), .GUARD(1), .HEX_EN(0), .LZB_EN(1),
                      .DIG_ACT_LOW(1), .SEG_ACT_LOW(0)) dut0 (
      .clk_i(clk), .rst_i(rst), .load_i(load), .num_i(num), .dp_i(dp),
      .seg_o(seg0), .dp_out_o(dpo0), .an_o(an0), .frame_o(frm0));
   seg7_scan_driver #(.N_DIGITS(4), .DIV(4), .GUARD(1), .HEX_EN(1), .LZB_EN(1),
                      .DIG_ACT_LOW(1), .SEG_ACT_LOW(0)) dut1 (
      .clk_i(clk), .rst_i(rst), .load_i(load), .num_i(num), .dp_i(dp),
      .seg_o(seg1), .dp_out_o(dpo1), .an_o(an1), .frame_o(frm1));
   seg7_scan_driver #(.N_DIGITS(4), .DIV(4), .GUARD(1), .HEX_EN(0), .LZB_EN(1),
                      .DIG_ACT_LOW(0), .SEG_ACT_LOW(1)) dut2 (
      .clk_i(clk), .rst_i(rst), .load_i(load), .num_i(num), .dp_i(dp),
      .seg_o(seg2), .dp_out_o(dpo2), .an_o(an2), .frame_o(frm2));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic do_load(input logic [19:0] v);
      load = 1'b1;
      {dp, num} = v;
      @(posedge clk); #1;
      load = 1'b0;
   endtask

   task automatic wait_frame(output int n);
      n = 0;
      for (int k = 1; k <= 64; k++) begin
         @(posedge clk); #1;
         if (frm0) begin
            n = k;
            break;
         end
      end
      check("frame_seen", 32'(n != 0), 32'd1);
   endtask

   // Entered just after the edge that raised FRAME; walks the 16 cycles of one frame.
   task automatic check_frame(input logic [27:0] e0, input logic [27:0] e1, input logic [3:0] edp,
                              input int at1, input logic [19:0] v1,
                              input int at2, input logic [19:0] v2);
      int d;
      bit g;
      check("frame_pulse", 32'(frm0), 32'd1);
      for (int s = 0; s < 16; s++) begin
         @(posedge clk); #1;
         d = s / 4;
         g = (s % 4) == 0;
         if (s == 0) check("frame_low", 32'(frm0), 32'd0);
         check($sformatf("an0_s%0d", s),  32'(an0),  g ? 32'hF : 32'(~(4'b1 << d) & 4'hF));
         check($sformatf("seg0_s%0d", s), 32'(seg0), g ? 32'd0 : 32'(e0[7*d +: 7]));
         check($sformatf("dp0_s%0d", s),  32'(dpo0), g ? 32'd0 : 32'(edp[d]));
         check($sformatf("seg1_s%0d", s), 32'(seg1), g ? 32'd0 : 32'(e1[7*d +: 7]));
         check($sformatf("an2_s%0d", s),  32'(an2),  g ? 32'h0 : 32'((4'b1 << d) & 4'hF));
         check($sformatf("seg2_s%0d", s), 32'(seg2), g ? 32'h7F : 32'(~e0[7*d +: 7] & 7'h7F));
         check($sformatf("dp2_s%0d", s),  32'(dpo2), g ? 32'd1 : 32'(!edp[d]));
         if (s == at1) begin
            load = 1'b1; {dp, num} = v1;
         end else if (s == at2) begin
            load = 1'b1; {dp, num} = v2;
         end else begin
            load = 1'b0;
         end
      end
      load = 1'b0;
   endtask

   initial begin
      int n;
      rst = 1'b1; load = 1'b0; num = '0; dp = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_an0", 32'(an0), 32'hF);
      check("rst_seg0", 32'(seg0), 32'd0);
      check("rst_frame", 32'(frm0), 32'd0);
      check("rst_an2", 32'(an2), 32'h0);
      check("rst_seg2", 32'(seg2), 32'h7F);
      rst = 1'b0;

      // Plain digits, then mid-frame loads (last wins, no tearing), then boundary load.
      do_load(20'h01234);
      wait_frame(n);
      check_frame({G1, G2, G3, G4}, {G1, G2, G3, G4}, 4'b0000, 5, 20'h01111, 9, 20'h02222);
      check_frame({G2, G2, G2, G2}, {G2, G2, G2, G2}, 4'b0000, 14, 20'h00050, -1, 20'h0);
      check_frame({BL, BL, G5, G0}, {BL, BL, G5, G0}, 4'b0000, -1, 20'h0, -1, 20'h0);

      // Leading-zero blanking, including a DP that stops the blank run.
      do_load(20'h00000);
      wait_frame(n);
      check_frame({BL, BL, BL, G0}, {BL, BL, BL, G0}, 4'b0000, -1, 20'h0, -1, 20'h0);
      do_load(20'h40000);
      wait_frame(n);
      check_frame({BL, G0, G0, G0}, {BL, G0, G0, G0}, 4'b0100, -1, 20'h0, -1, 20'h0);

      // Codes 10..15.
      do_load(20'h0ABCF);
      wait_frame(n);
      check_frame({BL, BL, BL, BL}, {GA, GB, GC, GF}, 4'b0000, -1, 20'h0, -1, 20'h0);

      // Asynchronous reset in the middle of a frame.
      wait_frame(n);
      repeat (6) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("mid_rst_an0", 32'(an0), 32'hF);
      check("mid_rst_seg0", 32'(seg0), 32'd0);
      check("mid_rst_frame", 32'(frm0), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      load = 1'b1; {dp, num} = 20'h00009;
      @(posedge clk); #1;
      load = 1'b0;
      check("post_rst_c1_an0", 32'(an0), 32'hF);
      @(posedge clk); #1;
      check("post_rst_c2_an0", 32'(an0), 32'hE);
      check("post_rst_c2_seg0", 32'(seg0), 32'(G0));
      wait_frame(n);
      check("post_rst_frame_dist", 32'(n), 32'd14);
      check_frame({BL, BL, BL, G9}, {BL, BL, BL, G9}, 4'b0000, -1, 20'h0, -1, 20'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule

`default_nettype wire
